// File: rtl/glip_uart_transmit_if.sv
`default_nettype none
// ============================================================================
//  Module   : glip_uart_transmit_if
//  Brief    : Byte valid/ready handshake into the GLIP UART transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
interface glip_uart_transmit_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/glip_uart_transmit.sv
`default_nettype none
// ============================================================================
//  Module   : glip_uart_transmit
//  Brief    : 8N1 UART transmitter with a one-byte holding buffer so that
//             consecutive frames leave the tx pin with no idle gap.
//  Revision : 1.0 - initial release
// ============================================================================
module glip_uart_transmit #(
    // Clock cycles per UART bit; the instantiator sets this, legal values >= 2.
    parameter int unsigned DIVISOR = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    glip_uart_transmit_if.slave in_if,
    output logic                tx,
    output logic                busy
);

    localparam logic [31:0] c_DIV_RELOAD = 32'(DIVISOR - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BITS  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] divcounter_q;
    logic [2:0]  bitpos_q;
    logic [7:0]  shift_q;
    logic [7:0]  buf_q;
    logic        buf_valid_q;
    logic        tx_q;

    logic        w_bitend;
    logic        w_accept;

    assign w_bitend       = (divcounter_q == 32'd0);
    // Ready depends only on the buffer flag, never on in_valid.
    assign in_if.in_ready = ~buf_valid_q;
    assign w_accept       = in_if.in_valid & ~buf_valid_q;

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) | buf_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            divcounter_q <= 32'd0;
            bitpos_q     <= 3'd0;
            shift_q      <= 8'd0;
            buf_q        <= 8'd0;
            buf_valid_q  <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // A byte left in the buffer by a STOP-edge accept launches here.
                    if (buf_valid_q) begin
                        shift_q      <= buf_q;
                        buf_valid_q  <= 1'b0;
                        state_q      <= START;
                        tx_q         <= 1'b0;
                        divcounter_q <= c_DIV_RELOAD;
                    end else if (w_accept) begin
                        shift_q      <= in_if.in_data;
                        state_q      <= START;
                        tx_q         <= 1'b0;
                        divcounter_q <= c_DIV_RELOAD;
                    end
                end
                default: begin
                    divcounter_q <= w_bitend ? c_DIV_RELOAD : (divcounter_q - 32'd1);
                    if (w_accept) begin
                        buf_q       <= in_if.in_data;
                        buf_valid_q <= 1'b1;
                    end
                    if (w_bitend) begin
                        case (state_q)
                            START: begin
                                state_q  <= BITS;
                                bitpos_q <= 3'd0;
                                tx_q     <= shift_q[0];
                            end
                            BITS: begin
                                if (bitpos_q == 3'd7) begin
                                    state_q <= STOP;
                                    tx_q    <= 1'b1;
                                end else begin
                                    bitpos_q <= bitpos_q + 3'd1;
                                    tx_q     <= shift_q[bitpos_q + 3'd1];
                                end
                            end
                            STOP: begin
                                // Buffered byte follows immediately; accept is
                                // blocked this cycle because in_ready is low.
                                if (buf_valid_q) begin
                                    shift_q     <= buf_q;
                                    buf_valid_q <= 1'b0;
                                    state_q     <= START;
                                    tx_q        <= 1'b0;
                                end else begin
                                    state_q <= IDLE;
                                    tx_q    <= 1'b1;
                                end
                            end
                            default: begin
                                state_q <= IDLE;
                                tx_q    <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_glip_uart_transmit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_glip_uart_transmit
//  Brief    : Directed self-checking bench for glip_uart_transmit at DIVISOR
//             values 4, 5 and 2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_glip_uart_transmit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    glip_uart_transmit_if if4 ();
    glip_uart_transmit_if if5 ();
    glip_uart_transmit_if if2 ();

    logic tx4, tx5, tx2;
    logic busy4, busy5, busy2;

    glip_uart_transmit #(.DIVISOR(4)) u_d4 (.clk(clk), .rst(rst), .in_if(if4), .tx(tx4), .busy(busy4));
    glip_uart_transmit #(.DIVISOR(5)) u_d5 (.clk(clk), .rst(rst), .in_if(if5), .tx(tx5), .busy(busy5));
    glip_uart_transmit #(.DIVISOR(2)) u_d2 (.clk(clk), .rst(rst), .in_if(if2), .tx(tx2), .busy(busy2));

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_buf [256];
    int         rx_n;
    int         rx_err;
    int         rx_first_k;
    int         rx_end_k;

    function automatic logic get_tx(input int sel);
        case (sel)
            4:       return tx4;
            5:       return tx5;
            default: return tx2;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            4:       return if4.in_ready;
            5:       return if5.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            4:       return busy4;
            5:       return busy5;
            default: return busy2;
        endcase
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [7:0] d);
        case (sel)
            4:       begin if4.in_valid = v; if4.in_data = d; end
            5:       begin if5.in_valid = v; if5.in_data = d; end
            default: begin if2.in_valid = v; if2.in_data = d; end
        endcase
    endtask

    // Expected line level k cycles after the first start-bit cycle of byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int div, input int k);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[4'(k / div)];
    endfunction

    function automatic logic [7:0] dpat(input int c);
        return 8'((c * 37 + 11) % 256);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loopback receiver: samples each bit mid-period, stop bit must be 1.
    task automatic rx_run(input int sel, input int div, input int nframes, input int budget);
        int         k;
        int         start_k;
        int         off;
        int         bitn;
        logic       t;
        logic [7:0] b;
        k = 0; start_k = -1; b = 8'd0;
        rx_n = 0; rx_err = 0; rx_first_k = -1; rx_end_k = -1;
        while (k < budget) begin
            tick();
            t = get_tx(sel);
            if (start_k < 0) begin
                if (rx_n < nframes && t == 1'b0) begin
                    start_k = k;
                    if (rx_first_k < 0) rx_first_k = k;
                end else if (rx_n >= nframes && !get_busy(sel)) begin
                    rx_end_k = k;
                    break;
                end
            end else begin
                off = k - start_k;
                if (off >= div && (off % div) == div / 2) begin
                    bitn = off / div;
                    if (bitn <= 8) begin
                        b[3'(bitn - 1)] = t;
                    end else begin
                        if (t !== 1'b1) rx_err++;
                        rx_buf[rx_n] = b;
                        rx_n++;
                        start_k = -1;
                    end
                end
            end
            k++;
        end
    endtask

    task automatic test_reset();
        int sels [3];
        sels = '{4, 5, 2};
        set_in(4, 1'b0, 8'h00);
        set_in(5, 1'b0, 8'h00);
        set_in(2, 1'b0, 8'h00);
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({get_tx(sels[i]), get_ready(sels[i]), get_busy(sels[i])} !== 3'b110) begin
                failures++;
                $display("FAIL reset_state div=%0d got tx/ready/busy=%b%b%b expected 110",
                         sels[i], get_tx(sels[i]), get_ready(sels[i]), get_busy(sels[i]));
            end
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        logic [39:0] w, e;
        logic        rdy_ok;
        rdy_ok = 1'b1;
        set_in(4, 1'b1, 8'h55);
        if (if4.in_ready !== 1'b1) rdy_ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 0) set_in(4, 1'b0, 8'h00);
            w[k] = tx4;
            e[k] = exp_bit(8'h55, 4, k);
            if (if4.in_ready !== 1'b1) rdy_ok = 1'b0;
            if (k == 39) begin
                checks++;
                if (busy4 !== 1'b1) begin
                    failures++;
                    $display("FAIL t1_busy_before_end got=%b expected=1", busy4);
                end
            end
        end
        checks++;
        if (w !== e) begin
            failures++;
            $display("FAIL t1_wave got=%h expected=%h", w, e);
        end
        checks++;
        if (rdy_ok !== 1'b1) begin
            failures++;
            $display("FAIL t1_ready_high got=0 expected=1");
        end
        tick();
        checks++;
        if ({busy4, tx4} !== 2'b01) begin
            failures++;
            $display("FAIL t1_busy_fall got busy/tx=%b%b expected 01", busy4, tx4);
        end
    endtask

    task automatic test_back_to_back();
        logic [79:0] w, e;
        set_in(4, 1'b1, 8'hA5);
        for (int k = 0; k < 80; k++) begin
            tick();
            w[k] = tx4;
            e[k] = (k < 40) ? exp_bit(8'hA5, 4, k) : exp_bit(8'h3C, 4, k - 40);
            if (k == 0) begin
                checks++;
                if (if4.in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL t2_ready_after_first got=%b expected=1", if4.in_ready);
                end
                set_in(4, 1'b1, 8'h3C);
            end
            if (k == 1) begin
                checks++;
                if (if4.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL t2_ready_buffered got=%b expected=0", if4.in_ready);
                end
                set_in(4, 1'b0, 8'h00);
            end
        end
        checks++;
        if (w !== e) begin
            failures++;
            $display("FAIL t2_wave got=%h expected=%h", w, e);
        end
        tick();
        checks++;
        if (busy4 !== 1'b0) begin
            failures++;
            $display("FAIL t2_busy_end got=%b expected=0", busy4);
        end
    endtask

    task automatic test_stream();
        int   idx;
        int   cyc;
        int   dur;
        logic pr;
        idx = 0; cyc = 0;
        set_in(5, 1'b1, 8'h00);
        pr = if5.in_ready;
        fork
            begin
                while (idx < 256 && cyc < 14000) begin
                    tick();
                    cyc++;
                    if (pr) idx++;
                    if (idx < 256) set_in(5, 1'b1, 8'(idx));
                    else           set_in(5, 1'b0, 8'h00);
                    pr = if5.in_ready;
                end
                set_in(5, 1'b0, 8'h00);
            end
            rx_run(5, 5, 256, 13500);
        join
        checks++;
        if (rx_n !== 256 || rx_err !== 0) begin
            failures++;
            $display("FAIL t3_rx_count got frames=%0d stop_errors=%0d expected 256/0", rx_n, rx_err);
        end
        for (int i = 0; i < rx_n; i++) begin
            checks++;
            if (rx_buf[i] !== 8'(i)) begin
                failures++;
                $display("FAIL t3_byte idx=%0d got=%h expected=%h", i, rx_buf[i], 8'(i));
            end
        end
        // 256 frames of 10 bits at 5 cycles per bit.
        dur = rx_end_k - rx_first_k;
        checks++;
        if (rx_end_k < 0 || dur < 12799 || dur > 12801) begin
            failures++;
            $display("FAIL t3_duration got=%0d cycles expected=12800+/-1", dur);
        end
    endtask

    task automatic test_async_reset();
        logic ok;
        set_in(4, 1'b1, 8'h0F);
        tick();
        set_in(4, 1'b1, 8'h77);
        tick();
        set_in(4, 1'b0, 8'h00);
        repeat (20) tick();
        checks++;
        if ({tx4, if4.in_ready, busy4} !== 3'b001) begin
            failures++;
            $display("FAIL t4_pre_reset got tx/ready/busy=%b%b%b expected 001", tx4, if4.in_ready, busy4);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({tx4, if4.in_ready, busy4} !== 3'b110) begin
            failures++;
            $display("FAIL t4_async_reset got tx/ready/busy=%b%b%b expected 110", tx4, if4.in_ready, busy4);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (tx4 !== 1'b1 || busy4 !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL t4_no_residual got=activity expected=idle line");
        end
    endtask

    task automatic test_ready_independent();
        logic       indep;
        logic       r0, r1;
        logic [7:0] exp_b [4];
        exp_b = '{dpat(0), dpat(1), dpat(21), dpat(41)};
        indep = 1'b1;
        set_in(2, 1'b1, dpat(0));
        fork
            begin
                for (int c = 0; c <= 41; c++) begin
                    tick();
                    set_in(2, 1'b0, dpat(c + 1));
                    #1 r0 = if2.in_ready;
                    set_in(2, 1'b1, dpat(c + 1));
                    #1 r1 = if2.in_ready;
                    if (r0 !== r1) indep = 1'b0;
                    if (c == 41) set_in(2, 1'b0, 8'h00);
                end
            end
            rx_run(2, 2, 4, 150);
        join
        checks++;
        if (indep !== 1'b1) begin
            failures++;
            $display("FAIL t5_ready_indep got=dependent expected=independent");
        end
        checks++;
        if (rx_n !== 4 || rx_err !== 0) begin
            failures++;
            $display("FAIL t5_rx_count got frames=%0d stop_errors=%0d expected 4/0", rx_n, rx_err);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_buf[i] !== exp_b[i]) begin
                failures++;
                $display("FAIL t5_byte idx=%0d got=%h expected=%h", i, rx_buf[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_stop_edge_accept();
        logic [80:0] w, e;
        set_in(4, 1'b1, 8'h11);
        for (int k = 0; k <= 81; k++) begin
            tick();
            if (k <= 80) begin
                w[k] = tx4;
                if (k < 40)       e[k] = exp_bit(8'h11, 4, k);
                else if (k == 40) e[k] = 1'b1;
                else              e[k] = exp_bit(8'h81, 4, k - 41);
            end
            if (k == 0)  set_in(4, 1'b0, 8'h00);
            if (k == 39) set_in(4, 1'b1, 8'h81);
            if (k == 40) begin
                checks++;
                if ({if4.in_ready, busy4} !== 2'b01) begin
                    failures++;
                    $display("FAIL t6_buffered got ready/busy=%b%b expected 01", if4.in_ready, busy4);
                end
                set_in(4, 1'b0, 8'h00);
            end
            if (k == 81) begin
                checks++;
                if (busy4 !== 1'b0) begin
                    failures++;
                    $display("FAIL t6_busy_end got=%b expected=0", busy4);
                end
            end
        end
        checks++;
        if (w !== e) begin
            failures++;
            $display("FAIL t6_wave got=%h expected=%h", w, e);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        tick();
        test_back_to_back();
        tick();
        test_stream();
        tick();
        test_async_reset();
        test_ready_independent();
        tick();
        test_stop_edge_accept();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=completion");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
